// File: rtl/axis_measure_sequencer_pkg.sv
// Shared definitions for the measurement sequencer: measurer register map,
// control words, AXI response codes and the state encodings.
package axis_measure_sequencer_pkg;

    localparam int STORE_DATA_WIDTH = 32;

    localparam logic [31:0] CONTROL_OFFSET    = 32'h0000_0000;
    localparam logic [31:0] CYCLES_OFFSET     = 32'h0000_0010;
    localparam logic [31:0] LAST_FRAME_OFFSET = 32'h0000_0018;

    localparam logic [31:0] SIG_START = 32'h0000_0001;
    localparam logic [31:0] SIG_CLEAR = 32'h0000_0002;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_CLR,
        ST_WR_STA,
        ST_WAIT,
        ST_RD_HI0,
        ST_RD_LO,
        ST_RD_HI1,
        ST_RD_FRM,
        ST_EMIT,
        ST_DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_ADDR,
        ENG_B,
        ENG_AR,
        ENG_R
    } eng_state_t;

endpackage

// File: rtl/axis_measure_sequencer_axil.sv
// Single-outstanding AXI-lite master engine (axil_master_single): one read or
// write per request, ack pulses in the cycle the B or R handshake completes.
module axil_master_single
    import axis_measure_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req,
    input  logic                        we,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [STORE_DATA_WIDTH-1:0] wdata,
    output logic                        ack,
    output logic [STORE_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                  resp,
    output logic [ADDR_WIDTH-1:0]       awaddr,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [STORE_DATA_WIDTH-1:0] axi_wdata,
    output logic [3:0]                  wstrb,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    output logic [ADDR_WIDTH-1:0]       araddr,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [STORE_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rvalid,
    output logic                        rready
);

    eng_state_t state, state_next;
    logic aw_done, w_done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STORE_DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ENG_IDLE;
        else        state <= state_next;
    end

    // AW and W complete independently; B is awaited only once both are done.
    always_comb begin
        state_next = state;
        case (state)
            ENG_IDLE: if (req) state_next = we ? ENG_ADDR : ENG_AR;
            ENG_ADDR: if ((aw_done || awready) && (w_done || wready)) state_next = ENG_B;
            ENG_B:    if (bvalid) state_next = ENG_IDLE;
            ENG_AR:   if (arready) state_next = ENG_R;
            ENG_R:    if (rvalid) state_next = ENG_IDLE;
            default:  state_next = ENG_IDLE;
        endcase
    end

    always_comb begin
        awvalid   = (state == ENG_ADDR) && !aw_done;
        wvalid    = (state == ENG_ADDR) && !w_done;
        bready    = (state == ENG_B);
        arvalid   = (state == ENG_AR);
        rready    = (state == ENG_R);
        awaddr    = addr_q;
        araddr    = addr_q;
        axi_wdata = wdata_q;
        wstrb     = 4'hF;
        ack       = ((state == ENG_B) && bvalid) || ((state == ENG_R) && rvalid);
        rdata     = axi_rdata;
        resp      = (state == ENG_B) ? bresp : rresp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == ENG_IDLE) begin
            if (req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end else if (state == ENG_ADDR) begin
            if (awready) aw_done <= 1'b1;
            if (wready)  w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_measure_sequencer.sv
// Sequences one measurer over AXI-lite: clear, start, then periodic tear-free
// 64-bit cycle/frame sampling emitted as 96-bit AXI-stream beats.
module axis_measure_sequencer
    import axis_measure_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_WIDTH-1:0]  sample_period,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  sample_count,
    output logic [ADDR_WIDTH-1:0] m_axi_control_awaddr,
    output logic                  m_axi_control_awvalid,
    input  logic                  m_axi_control_awready,
    output logic [31:0]           m_axi_control_wdata,
    output logic [3:0]            m_axi_control_wstrb,
    output logic                  m_axi_control_wvalid,
    input  logic                  m_axi_control_wready,
    input  logic [1:0]            m_axi_control_bresp,
    input  logic                  m_axi_control_bvalid,
    output logic                  m_axi_control_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_control_araddr,
    output logic                  m_axi_control_arvalid,
    input  logic                  m_axi_control_arready,
    input  logic [31:0]           m_axi_control_rdata,
    input  logic [1:0]            m_axi_control_rresp,
    input  logic                  m_axi_control_rvalid,
    output logic                  m_axi_control_rready,
    output logic [95:0]           m_axis_sample_tdata,
    output logic                  m_axis_sample_tvalid,
    input  logic                  m_axis_sample_tready,
    output logic                  m_axis_sample_tlast
);

    seq_state_t state, state_next;
    logic [CNT_WIDTH-1:0] period_lat, num_lat, period_cnt;
    logic [31:0] hi0, lo, frame;
    logic stop_pending;
    logic req, we, ack;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0] req_wdata, rdata;
    logic [1:0] resp;

    logic start_ok, stop_now, emit_fire, bounded_last;
    assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign stop_now     = stop_pending || stop;
    assign emit_fire    = (state == ST_EMIT) && m_axis_sample_tready;
    assign bounded_last = (num_lat != '0) && ((sample_count + CNT_WIDTH'(1)) == num_lat);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= ST_IDLE;
        else           state <= state_next;
    end

    // A stop never abandons an AXI transaction; it only redirects at safe points.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_WR_CLR;
            ST_WR_CLR: if (ack) state_next = ST_WR_STA;
            ST_WR_STA: if (ack) state_next = stop_now ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (stop_now)                             state_next = ST_DONE;
                else if (period_cnt <= CNT_WIDTH'(1))     state_next = ST_RD_HI0;
            end
            ST_RD_HI0: if (ack) state_next = ST_RD_LO;
            ST_RD_LO:  if (ack) state_next = ST_RD_HI1;
            ST_RD_HI1: if (ack) state_next = (rdata != hi0) ? ST_RD_LO : ST_RD_FRM;
            ST_RD_FRM: if (ack) state_next = ST_EMIT;
            ST_EMIT: begin
                if (m_axis_sample_tready)
                    state_next = (bounded_last || stop_now) ? ST_DONE : ST_WAIT;
            end
            ST_DONE:   state_next = start ? ST_WR_CLR : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req       = 1'b0;
        we        = 1'b0;
        req_addr  = BASE_ADDR + ADDR_WIDTH'(CONTROL_OFFSET);
        req_wdata = SIG_CLEAR;
        case (state)
            ST_WR_CLR: begin
                req = 1'b1;
                we  = 1'b1;
            end
            ST_WR_STA: begin
                req       = 1'b1;
                we        = 1'b1;
                req_wdata = SIG_START;
            end
            ST_RD_HI0, ST_RD_HI1: begin
                req      = 1'b1;
                req_addr = BASE_ADDR + ADDR_WIDTH'(CYCLES_OFFSET + 32'd4);
            end
            ST_RD_LO: begin
                req      = 1'b1;
                req_addr = BASE_ADDR + ADDR_WIDTH'(CYCLES_OFFSET);
            end
            ST_RD_FRM: begin
                req      = 1'b1;
                req_addr = BASE_ADDR + ADDR_WIDTH'(LAST_FRAME_OFFSET);
            end
            default: ;
        endcase
        busy                 = (state != ST_IDLE) && (state != ST_DONE);
        done                 = (state == ST_DONE);
        m_axis_sample_tvalid = (state == ST_EMIT);
        m_axis_sample_tlast  = (state == ST_EMIT) && (bounded_last || stop_now);
        m_axis_sample_tdata  = {frame, hi0, lo};
    end

    // Period counter counts down from P-1 so the next sample starts P cycles
    // after the reload point (WR_STA completion or the EMIT handshake).
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            period_lat   <= '0;
            num_lat      <= '0;
            period_cnt   <= '0;
            sample_count <= '0;
            error        <= 1'b0;
            stop_pending <= 1'b0;
            hi0          <= '0;
            lo           <= '0;
            frame        <= '0;
        end else begin
            if (start_ok) begin
                period_lat   <= (sample_period == '0) ? CNT_WIDTH'(1) : sample_period;
                num_lat      <= num_samples;
                sample_count <= '0;
                error        <= 1'b0;
                stop_pending <= 1'b0;
            end else begin
                if (stop && busy)                error        <= error;
                if (stop && busy)                stop_pending <= 1'b1;
                if (ack && (resp != RESP_OKAY))  error        <= 1'b1;
                if (emit_fire)                   sample_count <= sample_count + CNT_WIDTH'(1);
            end
            if (ack) begin
                case (state)
                    ST_RD_HI0, ST_RD_HI1: hi0   <= rdata;
                    ST_RD_LO:             lo    <= rdata;
                    ST_RD_FRM:            frame <= rdata;
                    default: ;
                endcase
            end
            if (((state == ST_WR_STA) && ack) || emit_fire)
                period_cnt <= period_lat - CNT_WIDTH'(1);
            else if ((state == ST_WAIT) && (period_cnt > CNT_WIDTH'(1)))
                period_cnt <= period_cnt - CNT_WIDTH'(1);
        end
    end

    axil_master_single #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_axil (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .req       (req),
        .we        (we),
        .addr      (req_addr),
        .wdata     (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .resp      (resp),
        .awaddr    (m_axi_control_awaddr),
        .awvalid   (m_axi_control_awvalid),
        .awready   (m_axi_control_awready),
        .axi_wdata (m_axi_control_wdata),
        .wstrb     (m_axi_control_wstrb),
        .wvalid    (m_axi_control_wvalid),
        .wready    (m_axi_control_wready),
        .bresp     (m_axi_control_bresp),
        .bvalid    (m_axi_control_bvalid),
        .bready    (m_axi_control_bready),
        .araddr    (m_axi_control_araddr),
        .arvalid   (m_axi_control_arvalid),
        .arready   (m_axi_control_arready),
        .axi_rdata (m_axi_control_rdata),
        .rresp     (m_axi_control_rresp),
        .rvalid    (m_axi_control_rvalid),
        .rready    (m_axi_control_rready)
    );

endmodule

// File: tb/tb_axis_measure_sequencer.sv
// Directed bench for axis_measure_sequencer with a scripted AXI-lite slave
// (random AW/W/AR skew) and an AXI-stream sink monitor.
module tb_axis_measure_sequencer;
    import axis_measure_sequencer_pkg::*;

    localparam int AW = 32;
    localparam int CW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] sample_period = '0;
    logic [CW-1:0] num_samples = '0;
    logic          busy, done, error;
    logic [CW-1:0] sample_count;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [31:0]   rdata = '0;
    logic [95:0]   tdata;
    logic          tvalid, tlast;
    logic          tready = 1'b0;

    int check_count = 0;
    int error_count = 0;

    // Slave model and monitor state
    logic [31:0] hi_q[$], lo_q[$], frm_q[$];
    logic [63:0] wr_log[$];
    logic [96:0] beats[$];
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, lo_reads = 0;
    int violations = 0, tviol = 0, runs = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0, frm_err_once = 1'b0;
    logic [31:0] aw_a = '0, w_d = '0, r_data = '0;
    logic [1:0]  r_resp = 2'b00;
    logic [95:0] prev_tdata = '0;
    logic        prev_stall = 1'b0;

    always #5 ap_clk = ~ap_clk;

    axis_measure_sequencer #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR ('0),
        .CNT_WIDTH (CW)
    ) dut (
        .ap_clk               (ap_clk),
        .ap_rst_n             (ap_rst_n),
        .start                (start),
        .stop                 (stop),
        .sample_period        (sample_period),
        .num_samples          (num_samples),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .sample_count         (sample_count),
        .m_axi_control_awaddr (awaddr),
        .m_axi_control_awvalid(awvalid),
        .m_axi_control_awready(awready),
        .m_axi_control_wdata  (wdata),
        .m_axi_control_wstrb  (wstrb),
        .m_axi_control_wvalid (wvalid),
        .m_axi_control_wready (wready),
        .m_axi_control_bresp  (bresp),
        .m_axi_control_bvalid (bvalid),
        .m_axi_control_bready (bready),
        .m_axi_control_araddr (araddr),
        .m_axi_control_arvalid(arvalid),
        .m_axi_control_arready(arready),
        .m_axi_control_rdata  (rdata),
        .m_axi_control_rresp  (rresp),
        .m_axi_control_rvalid (rvalid),
        .m_axi_control_rready (rready),
        .m_axis_sample_tdata  (tdata),
        .m_axis_sample_tvalid (tvalid),
        .m_axis_sample_tready (tready),
        .m_axis_sample_tlast  (tlast)
    );

    // Slave decides its ready/valid outputs on the falling edge for the next rising edge.
    always @(negedge ap_clk) begin
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        if (!ap_rst_n) begin
            aw_got = 1'b0;
            w_got  = 1'b0;
            b_pend = 1'b0;
            r_pend = 1'b0;
        end else begin
            if (aw_got && w_got) begin
                wr_log.push_back({aw_a, w_d});
                aw_got = 1'b0;
                w_got  = 1'b0;
                b_pend = 1'b1;
                aw_dly = $urandom_range(0, 3);
                w_dly  = $urandom_range(0, 3);
            end
            if (b_pend) begin
                bvalid = 1'b1;
                bresp  = RESP_OKAY;
                if (bready) begin
                    b_pend = 1'b0;
                    b_cnt++;
                end
            end
            if (r_pend) begin
                rvalid = 1'b1;
                rdata  = r_data;
                rresp  = r_resp;
                if (rready) r_pend = 1'b0;
            end
            if (arvalid) begin
                if (r_pend || rvalid || aw_got || w_got || b_pend || bvalid || awvalid || wvalid)
                    violations++;
                else if (ar_dly == 0) begin
                    arready = 1'b1;
                    ar_cnt++;
                    r_resp = RESP_OKAY;
                    if (araddr == CYCLES_OFFSET + 32'd4) begin
                        r_data = (hi_q.size() > 0) ? hi_q.pop_front() : 32'h0;
                    end else if (araddr == CYCLES_OFFSET) begin
                        lo_reads++;
                        r_data = (lo_q.size() > 0) ? lo_q.pop_front() : 32'h0;
                    end else if (araddr == LAST_FRAME_OFFSET) begin
                        r_data = (frm_q.size() > 0) ? frm_q.pop_front() : 32'h0;
                        if (frm_err_once) begin
                            r_resp = RESP_SLVERR;
                            frm_err_once = 1'b0;
                        end
                    end else begin
                        r_data = 32'h0;
                    end
                    r_pend = 1'b1;
                    ar_dly = $urandom_range(0, 3);
                end else begin
                    ar_dly--;
                end
            end
            if (awvalid) begin
                if (aw_got || b_pend) violations++;
                else if (aw_dly == 0) begin
                    awready = 1'b1;
                    aw_got  = 1'b1;
                    aw_a    = awaddr;
                    aw_cnt++;
                end else begin
                    aw_dly--;
                end
            end
            if (wvalid) begin
                if (w_got || b_pend || wstrb != 4'hF) violations++;
                else if (w_dly == 0) begin
                    wready = 1'b1;
                    w_got  = 1'b1;
                    w_d    = wdata;
                    w_cnt++;
                end else begin
                    w_dly--;
                end
            end
        end
    end

    // Stream sink: logs accepted beats and flags any change while stalled.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(tvalid && tdata == prev_tdata)) tviol++;
            if (tvalid && tready) beats.push_back({tlast, tdata});
            prev_stall = tvalid && !tready;
            prev_tdata = tdata;
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [CW-1:0] period, input logic [CW-1:0] num);
        beats.delete();
        sample_period = period;
        num_samples   = num;
        start = 1'b1;
        runs++;
        tick();
        start = 1'b0;
    endtask

    // Waits for the done pulse, then checks busy is low and done lasts one cycle.
    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        checkOutput({tag, "_done_seen"}, done, 1'b1);
        checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
        tick();
        checkOutput({tag, "_done_pulse"}, done, 1'b0);
        checkOutput({tag, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic checkBeat(input string tag, input int idx, input logic [95:0] exp_data, input logic exp_last);
        if (beats.size() > idx) begin
            checkOutput({tag, "_tdata"}, beats[idx][95:0], exp_data);
            checkOutput({tag, "_tlast"}, beats[idx][96], exp_last);
        end else begin
            checkOutput({tag, "_present"}, 1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [95:0] held;
        int ar_before;
        int n;

        $display("[TB] reset");
        repeat (3) tick();
        checkOutput("rst_awvalid", awvalid, 1'b0);
        checkOutput("rst_arvalid", arvalid, 1'b0);
        ap_rst_n = 1'b1;
        tick();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_tvalid", tvalid, 1'b0);
        checkOutput("rst_tlast", tlast, 1'b0);
        checkOutput("rst_count", sample_count, '0);

        $display("[TB] bounded run, period 4, two samples");
        tready = 1'b1;
        hi_q = '{32'h0, 32'h0, 32'h0, 32'h0};
        lo_q = '{32'h100, 32'h200};
        frm_q = '{32'hA1, 32'hA2};
        applyStimulus(4, 2);
        checkOutput("t1_busy", busy, 1'b1);
        waitDone("t1");
        checkOutput("t1_wr_count", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            checkOutput("t1_wr_clear", wr_log[0], {CONTROL_OFFSET, SIG_CLEAR});
            checkOutput("t1_wr_start", wr_log[1], {CONTROL_OFFSET, SIG_START});
        end
        checkOutput("t1_beats", beats.size(), 2);
        checkBeat("t1_b0", 0, {32'hA1, 32'h0, 32'h100}, 1'b0);
        checkBeat("t1_b1", 1, {32'hA2, 32'h0, 32'h200}, 1'b1);
        checkOutput("t1_count", sample_count, 2);

        $display("[TB] torn counter read");
        hi_q = '{32'h0, 32'h1, 32'h1};
        lo_q = '{32'hFFFF_FFFF, 32'h10};
        frm_q = '{32'hB0};
        lo_reads = 0;
        applyStimulus(2, 1);
        waitDone("t3");
        checkOutput("t3_lo_reads", lo_reads, 2);
        checkBeat("t3_b0", 0, {32'hB0, 32'h1, 32'h10}, 1'b1);

        $display("[TB] downstream stall");
        tready = 1'b0;
        hi_q = '{32'h7, 32'h7};
        lo_q = '{32'h77};
        frm_q = '{32'hD7};
        applyStimulus(1, 1);
        n = 0;
        while (!tvalid && n < 300) begin
            tick();
            n++;
        end
        checkOutput("t4_tvalid_up", tvalid, 1'b1);
        held = tdata;
        ar_before = ar_cnt;
        repeat (10) tick();
        checkOutput("t4_tvalid_held", tvalid, 1'b1);
        checkOutput("t4_tdata_held", tdata, held);
        checkOutput("t4_no_new_ar", ar_cnt, ar_before);
        tready = 1'b1;
        waitDone("t4");
        checkBeat("t4_b0", 0, {32'hD7, 32'h7, 32'h77}, 1'b1);

        $display("[TB] stop during low-word read, unlimited run");
        hi_q = '{32'h5, 32'h5};
        lo_q = '{32'h55};
        frm_q = '{32'hC5};
        applyStimulus(3, 0);
        n = 0;
        while (!(arvalid && araddr == CYCLES_OFFSET) && n < 300) begin
            tick();
            n++;
        end
        checkOutput("t5_lo_read_seen", arvalid && araddr == CYCLES_OFFSET, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        waitDone("t5");
        checkOutput("t5_beats", beats.size(), 1);
        checkBeat("t5_b0", 0, {32'hC5, 32'h5, 32'h55}, 1'b1);
        checkOutput("t5_count", sample_count, 1);

        $display("[TB] error response on frame read");
        hi_q = '{32'h0, 32'h0, 32'h0, 32'h0};
        lo_q = '{32'h1, 32'h2};
        frm_q = '{32'hF1, 32'hF2};
        frm_err_once = 1'b1;
        applyStimulus(2, 2);
        n = 0;
        while (beats.size() < 1 && n < 300) begin
            tick();
            n++;
        end
        tick();
        checkOutput("t6_error_set", error, 1'b1);
        waitDone("t6");
        checkOutput("t6_error_sticky", error, 1'b1);
        checkBeat("t6_b0", 0, {32'hF1, 32'h0, 32'h1}, 1'b0);
        checkBeat("t6_b1", 1, {32'hF2, 32'h0, 32'h2}, 1'b1);
        hi_q = '{32'h0, 32'h0};
        lo_q = '{32'h3};
        frm_q = '{32'hF3};
        applyStimulus(2, 1);
        checkOutput("t6_error_cleared", error, 1'b0);
        waitDone("t6b");
        checkOutput("t6b_error", error, 1'b0);
        checkBeat("t6b_b0", 0, {32'hF3, 32'h0, 32'h3}, 1'b1);

        tick();
        checkOutput("aw_count", aw_cnt, runs * 2);
        checkOutput("w_count", w_cnt, runs * 2);
        checkOutput("b_count", b_cnt, runs * 2);
        checkOutput("axi_protocol", violations, 0);
        checkOutput("stream_stability", tviol, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
